cache_line_mem_responder: RTL

Memory-side responder for the cache's line-fill/writeback port. It serves whole-line bursts requested by the cache miss handler.
- Read request: streams LINE_SIZE data beats back to the cache.
- Write request: absorbs LINE_SIZE beats and acknowledges completion.

It holds a byte-wide backing store and is the slave end of the cache↔memory interface, used as the memory model in cache integration benches and as the on-chip backing RAM.

---
 rtl/cache_line_mem_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cache_line_mem_responder.sv
// Memory-side slave for the cache line-fill/writeback port: streams or absorbs
// whole LINE_SIZE-beat bursts against a byte-wide backing store.
module cache_line_mem_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int LINE_SIZE     = 256,
  parameter int OFFSET_BITS   = $clog2(LINE_SIZE),
  parameter int MEM_BYTES     = 4096,
  parameter int MEM_ADDR_BITS = $clog2(MEM_BYTES),
  parameter int READ_LATENCY  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  rlast,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  output logic                  wr_done,
  output logic                  wr_err
);

  localparam int LINE_BITS = MEM_ADDR_BITS - OFFSET_BITS;
  localparam int LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_RESP
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_BYTES];
  logic [LINE_BITS-1:0]    base_q;
  logic [OFFSET_BITS-1:0]  cnt_q;
  logic [LAT_W-1:0]        lat_q;
  logic                    err_q;
  logic                    req_ready_q;
  logic                    rvalid_q;
  logic                    rlast_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    wready_q;
  logic                    wr_done_q;
  logic                    wr_err_q;

  logic [OFFSET_BITS-1:0]  cnt_nxt;
  logic                    beat_last;
  logic                    rd_fire;
  logic                    wr_fire;
  logic [LINE_BITS-1:0]    req_base;
  logic                    unused_addr_bits;

  assign cnt_nxt   = cnt_q + OFFSET_BITS'(1);
  assign beat_last = (cnt_q == OFFSET_BITS'(LINE_SIZE - 1));
  assign rd_fire   = rvalid_q && rready;
  assign wr_fire   = wready_q && wvalid;
  // Offset bits are dropped (align down) and upper bits ignored (aliasing).
  assign req_base  = req_addr[MEM_ADDR_BITS-1:OFFSET_BITS];
  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS], req_addr[OFFSET_BITS-1:0]};

  assign req_ready = req_ready_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign rdata     = rdata_q;
  assign wready    = wready_q;
  assign wr_done   = wr_done_q;
  assign wr_err    = wr_err_q;

  // Store has no reset; wready_q is cleared by reset, so an aborted burst stops writing at once.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[{base_q, cnt_q}] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      wready_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      cnt_q       <= '0;
      lat_q       <= '0;
      err_q       <= 1'b0;
      base_q      <= '0;
    end else begin
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            base_q      <= req_base;
            cnt_q       <= '0;
            lat_q       <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            if (req_write) begin
              state_q  <= WR_BURST;
              wready_q <= 1'b1;
            end else begin
              state_q  <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Accept edge plus READ_LATENCY-1 waiting edges puts the first beat at +READ_LATENCY.
          if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
            state_q  <= RD_BURST;
            rvalid_q <= 1'b1;
            rdata_q  <= mem_q[{base_q, cnt_q}];
            rlast_q  <= (LINE_SIZE == 1);
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        RD_BURST: begin
          if (rd_fire) begin
            if (beat_last) begin
              state_q     <= IDLE;
              rvalid_q    <= 1'b0;
              rlast_q     <= 1'b0;
              req_ready_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              cnt_q   <= cnt_nxt;
              rdata_q <= mem_q[{base_q, cnt_nxt}];
              rlast_q <= (cnt_nxt == OFFSET_BITS'(LINE_SIZE - 1));
            end
          end
        end
        WR_BURST: begin
          if (wr_fire) begin
            cnt_q <= cnt_nxt;
            // Burst length is fixed; wlast only feeds the framing-error flag.
            if (beat_last) begin
              state_q   <= WR_RESP;
              wready_q  <= 1'b0;
              wr_done_q <= 1'b1;
              wr_err_q  <= err_q | ~wlast;
              err_q     <= 1'b0;
            end else begin
              err_q <= err_q | wlast;
            end
          end
        end
        WR_RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rvalid_q    <= 1'b0;
          rlast_q     <= 1'b0;
          wready_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
